// File: rtl/add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The ovf output is optional and appears only when SERIAL_ADD_OVF_EN is defined.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Two-input NAND, the only gate the bit cell is built from.
  function automatic logic sheffer(input logic x, input logic y);
    return ~(x & y);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from nine NAND gates.
// This is the bit cell that the serial adder reuses for every bit position.
module full_adder
  import add_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic n1, n2, n3, x1, n4, n5, n6;

  // The first NAND half-adder gives x1 = a ^ b.
  // The second NAND half-adder folds in ci.
  assign n1 = sheffer(a, b);
  assign n2 = sheffer(a, n1);
  assign n3 = sheffer(b, n1);
  assign x1 = sheffer(n2, n3);
  assign n4 = sheffer(x1, ci);
  assign n5 = sheffer(x1, n4);
  assign n6 = sheffer(ci, n4);
  assign s  = sheffer(n5, n6);
  assign co = sheffer(n4, n1);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller that computes one bit per cycle, starting at the LSB.
// It uses a single shared full_adder.
// The optional ovf output (signed overflow) is present only when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  assign last_bit = (idx == IDX_W'(WIDTH - 1));

  full_adder u_fa (
    .a  (op_a[idx]),
    .b  (op_b[idx]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // This FSM sequences IDLE/RUN/DONE, feeds the adder one bit per cycle and registers every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[idx] <= fa_s;
          carry    <= fa_co;
          if (last_bit) begin
            // idx stays at WIDTH-1 so that it never points past the MSB.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= carry ^ fa_co;
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with WIDTH=8.
// It checks the ovf output as well when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge with the given operands.
  // On return the time is #1 after the accepting edge k.
  task automatic pulse_start(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    start = 1'b1; a = va; b = vb; cin = vc;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
  endtask

  // Run one addition and check its latency, busy length, result and hold behaviour.
  task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    pulse_start(va, vb, vc);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_busy_cycles"}, busy_cnt, 8);
    chk({tag, "_sum"}, {24'h0, sum}, {24'h0, es});
    chk({tag, "_cout"}, {31'h0, cout}, {31'h0, ec});
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, {31'h0, ovf}, {31'h0, eo});
`else
    if (eo === 1'bx) $display("unused");
`endif
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'h0, done}, 32'h0);
    chk({tag, "_sum_hold"}, {24'h0, sum}, {24'h0, es});
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_sum", {24'h0, sum}, 32'h0);
    chk("reset_cout", {31'h0, cout}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_add("basic",  8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_add("wrap1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("wrap2",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_add("sovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_add("altbit", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    run_add("small",  8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 1'b0);

    // A start pulse raised during RUN, around bit 3, must be ignored.
    pulse_start(8'h03, 8'h04, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00;
    dn = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        chk("ign_sum_at_done", {24'h0, sum}, 32'h07);
      end
    end
    chk("ign_done_count", dn, 1);
    chk("ign_sum_hold", {24'h0, sum}, 32'h07);

    // Asserting reset at bit 4 aborts the addition, and no done pulse may follow.
    pulse_start(8'h12, 8'h34, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_sum", {24'h0, sum}, 32'h0);
    chk("rstmid_cout", {31'h0, cout}, 32'h0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("rstmid_no_done", dn, 0);

    // When rst and start are high at the same edge, reset wins.
    rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("rst_start_idle", {31'h0, busy}, 32'h0);

    // Holding start high across DONE starts a second addition back to back.
    @(posedge clk); #1;
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20;
    repeat (7) @(posedge clk);
    #1;
    chk("b2b_first_not_yet", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    chk("b2b_first_done", {31'h0, done}, 32'h1);
    chk("b2b_first_sum", {24'h0, sum}, 32'h03);
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00;
    chk("b2b_restart_busy", {31'h0, busy}, 32'h1);
    chk("b2b_restart_sum_clr", {24'h0, sum}, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    chk("b2b_second_not_yet", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    chk("b2b_second_done", {31'h0, done}, 32'h1);
    chk("b2b_second_sum", {24'h0, sum}, 32'h30);
    @(posedge clk); #1;
    chk("b2b_back_idle", {31'h0, busy | done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
